morse_key_timer: RTL
====================

Name: morse_key_timer

Overview:
- Single-key Morse front end, upstream of the code-assembly stage.
- Times presses and releases of one debounced key, classifies each press as dot or dash, and ends a letter automatically after a long enough release.
- Output pulses drive the dot/dash/send inputs of the code-assembly stage, so the user needs only one key and no send button.

Parameters:
- TICK_DIV, 100000: clk cycles per timing tick (1 ms at 100 MHz).
- MIN_PRESS_MS, 10: presses shorter than this many ticks are glitches and are discarded.
- DASH_MIN_MS, 200: presses of at least this many ticks are dashes; shorter valid presses are dots.
- LETTER_GAP_MS, 600: release time in ticks that ends a letter.
- MAX_SYMBOLS, 5: maximum symbols per letter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous reset, active low.
- key  in  1  debounced key level, 1 = pressed; asynchronous to clk.
- dot_pulse  out  1  one-cycle strobe for a dot.
- dash_pulse  out  1  one-cycle strobe for a dash.
- send_pulse  out  1  one-cycle strobe for letter complete.
- key_active  out  1  high while state is PRESS.
- sym_count  out  3  symbols accepted in the current letter.
- overflow  out  1  sticky; set when a symbol is dropped, cleared by send_pulse.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, synchronizer flops 0.
- Synchronizer and edges:
  - key passes through a 2-flop synchronizer; a third flop provides edge detection.
  - Rise/fall is detected 3 clk after the raw edge.
  - Any strobe asserts the cycle after edge detection.
- Tick generation:
  - Prescaler counts 0..TICK_DIV-1 and emits tick on terminal count.
  - Prescaler is cleared on every detected edge and on every state change.
- ms counter:
  - 16-bit, increments on tick, saturates at 0xFFFF.
  - Cleared on every state change.
- FSM, state IDLE:
  - rise -> PRESS.
- FSM, state PRESS:
  - fall with ms < MIN_PRESS_MS -> no strobe. Go to GAP if sym_count > 0, else IDLE.
  - fall with MIN_PRESS_MS <= ms < DASH_MIN_MS -> dot_pulse, sym_count += 1, go to GAP.
  - fall with ms >= DASH_MIN_MS -> dash_pulse, sym_count += 1, go to GAP.
  - If sym_count == MAX_SYMBOLS at classification: no strobe, overflow <= 1, go to GAP.
- FSM, state GAP:
  - rise -> PRESS.
  - ms reaches LETTER_GAP_MS -> send_pulse, sym_count <= 0, overflow <= 0, go to IDLE.
- Boundaries:
  - Gap expiry and rise in the same cycle: send_pulse fires, sym_count clears, next state PRESS.
  - A held key never times out; the saturated count classifies as dash on release.
  - At most one strobe per cycle; dot_pulse and dash_pulse are mutually exclusive.
  - reset_n asserted mid-press or mid-gap: immediate return to reset values with no strobe. A key still held after release of reset_n is not a press until a fresh rise is seen.
- Parameter rule: MIN_PRESS_MS < DASH_MIN_MS < LETTER_GAP_MS.

Optional Feature:
- Macro: MORSE_WORD_GAP_EN.
- When defined:
  - Adds parameter WORD_GAP_MS, default 1400.
  - Adds output word_pulse (1 bit, reset 0).
  - After send_pulse, IDLE keeps counting, continuing from LETTER_GAP_MS without clearing ms.
  - When ms reaches WORD_GAP_MS, word_pulse fires once.
  - A rise before that cancels it.
  - Only one word_pulse per idle period; none after reset until at least one letter has been sent.
- When undefined:
  - No port, no extra logic.
  - IDLE does not count.

Test Plan (TICK_DIV=4, MIN_PRESS_MS=2, DASH_MIN_MS=5, LETTER_GAP_MS=8, MAX_SYMBOLS=5):
- Hold key 12 clk (3 ticks), release -> exactly one dot_pulse 4 clk after the raw fall; sym_count=1; 32 clk later (8 ticks) one send_pulse; sym_count=0.
- Hold key 28 clk (7 ticks) -> dash_pulse; then a 4-tick gap and a 3-tick press -> dot_pulse, sym_count=2, no send_pulse between them.
- Hold key 4 clk (1 tick) from IDLE -> no strobe, state returns to IDLE, sym_count=0.
- Six 3-tick presses with 2-tick gaps -> five dot_pulses; sixth dropped; overflow=1; then send_pulse clears overflow and sym_count.
- Pull reset_n low for 2 clk during a 6-tick press -> all outputs 0 immediately; no dash_pulse on later release; key held through reset produces no strobe.
- With MORSE_WORD_GAP_EN, WORD_GAP_MS=14: dot, then key idle -> send_pulse at tick 8, word_pulse at tick 14, no second word_pulse.

Source files
------------

// File: rtl/morse_key_timer.sv
// morse_key_timer: single-key Morse front end.
// Times presses and releases of one debounced key. Each press is classified as a
// dot or a dash, and a letter is closed automatically after a long enough release.
// The one-cycle strobes feed the dot/dash/send inputs of the code-assembly stage.
// Optional feature macro: MORSE_WORD_GAP_EN adds WORD_GAP_MS and the word_pulse output.
module morse_key_timer #(
    parameter int TICK_DIV      = 100000,
    parameter int MIN_PRESS_MS  = 10,
    parameter int DASH_MIN_MS   = 200,
    parameter int LETTER_GAP_MS = 600,
    parameter int MAX_SYMBOLS   = 5
`ifdef MORSE_WORD_GAP_EN
    ,
    parameter int WORD_GAP_MS   = 1400
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key,
    output logic       dot_pulse,
    output logic       dash_pulse,
    output logic       send_pulse,
    output logic       key_active,
    output logic [2:0] sym_count,
    output logic       overflow
`ifdef MORSE_WORD_GAP_EN
    ,
    output logic       word_pulse
`endif
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

    state_t        state;
    logic          key_s1;
    logic          key_s2;
    logic          key_s3;
    logic [2:0]    prime_sr;
    logic          rise_det;
    logic          fall_det;
    logic [PW-1:0] presc;
    logic [15:0]   ms;
    logic          counting;
    logic          tick;
    logic          gap_done;
    logic          state_change;
    logic          keep_ms;

`ifdef MORSE_WORD_GAP_EN
    logic          word_armed;
    logic          word_done;

    assign word_done = (state == IDLE) && word_armed && tick && (ms == 16'(WORD_GAP_MS - 1));
    assign keep_ms   = gap_done && !rise_det;
`else
    assign keep_ms   = 1'b0;
`endif

    assign key_active = (state == PRESS);
    assign tick       = counting && (presc == PW'(TICK_DIV - 1));
    assign gap_done   = (state == GAP) && tick && (ms == 16'(LETTER_GAP_MS - 1));

    // Two-flop synchronizer, a third flop for edge detection, and registered edge flags.
    // prime_sr masks edges until the chain has refilled after reset, so a key held
    // through reset is not mistaken for a fresh press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_s1   <= 1'b0;
            key_s2   <= 1'b0;
            key_s3   <= 1'b0;
            prime_sr <= 3'b000;
            rise_det <= 1'b0;
            fall_det <= 1'b0;
        end else begin
            key_s1   <= key;
            key_s2   <= key_s1;
            key_s3   <= key_s2;
            prime_sr <= {prime_sr[1:0], 1'b1};
            rise_det <= prime_sr[2] & key_s2 & ~key_s3;
            fall_det <= prime_sr[2] & ~key_s2 & key_s3;
        end
    end

    // Decide whether the timebase is running and whether the FSM leaves its state this cycle.
    always_comb begin
        counting     = (state == PRESS) || (state == GAP);
`ifdef MORSE_WORD_GAP_EN
        if ((state == IDLE) && word_armed) begin
            counting = 1'b1;
        end
`endif
        state_change = 1'b0;
        case (state)
            IDLE:    state_change = rise_det;
            PRESS:   state_change = fall_det;
            GAP:     state_change = rise_det | gap_done;
            default: state_change = 1'b0;
        endcase
    end

    // Tick prescaler and saturating millisecond counter, both restarted on edges and state changes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
            ms    <= '0;
        end else begin
            if (state_change || rise_det || fall_det || !counting || tick) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end
            if (state_change && !keep_ms) begin
                ms <= '0;
            end else if (tick && (ms != 16'hFFFF)) begin
                ms <= ms + 16'd1;
            end
        end
    end

    // Main FSM: classifies presses on release, closes letters after the gap, drives the strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            dot_pulse  <= 1'b0;
            dash_pulse <= 1'b0;
            send_pulse <= 1'b0;
            sym_count  <= 3'd0;
            overflow   <= 1'b0;
`ifdef MORSE_WORD_GAP_EN
            word_pulse <= 1'b0;
            word_armed <= 1'b0;
`endif
        end else begin
            dot_pulse  <= 1'b0;
            dash_pulse <= 1'b0;
            send_pulse <= 1'b0;
`ifdef MORSE_WORD_GAP_EN
            word_pulse <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (rise_det) begin
                        state <= PRESS;
                    end
`ifdef MORSE_WORD_GAP_EN
                    if (rise_det) begin
                        word_armed <= 1'b0;
                    end else if (word_done) begin
                        word_pulse <= 1'b1;
                        word_armed <= 1'b0;
                    end
`endif
                end
                PRESS: begin
                    if (fall_det) begin
                        if (ms < 16'(MIN_PRESS_MS)) begin
                            state <= (sym_count != 3'd0) ? GAP : IDLE;
                        end else if (sym_count == 3'(MAX_SYMBOLS)) begin
                            overflow <= 1'b1;
                            state    <= GAP;
                        end else begin
                            if (ms < 16'(DASH_MIN_MS)) begin
                                dot_pulse <= 1'b1;
                            end else begin
                                dash_pulse <= 1'b1;
                            end
                            sym_count <= sym_count + 3'd1;
                            state     <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        send_pulse <= 1'b1;
                        sym_count  <= 3'd0;
                        overflow   <= 1'b0;
                        state      <= rise_det ? PRESS : IDLE;
`ifdef MORSE_WORD_GAP_EN
                        word_armed <= !rise_det;
`endif
                    end else if (rise_det) begin
                        state <= PRESS;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
